// File: rtl/seq_divider_8b.sv
// seq_divider_8b: multi-cycle restoring divider producing one quotient bit per clock.
// Start/busy/done handshake; results stay registered until the next DONE.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds a signed_op input for two's complement
// division (truncating toward zero, remainder takes the dividend's sign).
module seq_divider_8b #(
    parameter int NBIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic            signed_op,
`endif
    input  logic [NBIT-1:0] dividend,
    input  logic [NBIT-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [NBIT-1:0] quotient,
    output logic [NBIT-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(NBIT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Partial remainder is always below the divisor after an iteration, so its
    // extra (NBIT+1)th bit is only needed transiently in the shifted/trial values.
    logic [NBIT-1:0] prem_q, prem_d;
    logic [NBIT-1:0] wdvd_q, wdvd_d;   // working dividend, becomes the quotient
    logic [NBIT-1:0] dvs_q, dvs_d;
    logic            zero_q, zero_d;
    logic            neg_q_q, neg_q_d; // negate quotient when loading results
    logic            neg_r_q, neg_r_d; // negate remainder when loading results
    logic            done_q, done_d;
    logic [NBIT-1:0] quo_q, quo_d;
    logic [NBIT-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [NBIT:0]   shifted;
    logic [NBIT:0]   trial;
    logic            sgn_a, sgn_b;
    logic [NBIT-1:0] mag_a, mag_b;

    // Operand signs and magnitudes for the accept cycle.
    always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn_a = signed_op & dividend[NBIT-1];
        sgn_b = signed_op & divisor[NBIT-1];
`else
        sgn_a = 1'b0;
        sgn_b = 1'b0;
`endif
        mag_a = sgn_a ? (~dividend + NBIT'(1)) : dividend;
        mag_b = sgn_b ? (~divisor + NBIT'(1)) : divisor;
    end

    // One shift-and-subtract step: the trial's MSB is the borrow.
    always_comb begin
        shifted = {prem_q, wdvd_q[NBIT-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    // State register and all working/result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            wdvd_q  <= '0;
            dvs_q   <= '0;
            zero_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            wdvd_q  <= wdvd_d;
            dvs_q   <= dvs_d;
            zero_q  <= zero_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        wdvd_d  = wdvd_q;
        dvs_d   = dvs_q;
        zero_d  = zero_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    prem_d  = '0;
                    dvs_d   = mag_b;
                    zero_d  = (divisor == '0);
                    neg_q_d = sgn_a ^ sgn_b;
                    neg_r_d = sgn_a;
                    cnt_d   = CW'(NBIT);
                    if (divisor == '0) begin
                        // Keep the raw dividend: it is returned as the remainder.
                        wdvd_d  = dividend;
                        state_d = DONE;
                    end else begin
                        wdvd_d  = mag_a;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                prem_d = trial[NBIT] ? shifted[NBIT-1:0] : trial[NBIT-1:0];
                wdvd_d = {wdvd_q[NBIT-2:0], ~trial[NBIT]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                done_d = 1'b1;
                if (zero_q) begin
                    quo_d = '1;
                    rem_d = wdvd_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = neg_q_q ? (~wdvd_q + NBIT'(1)) : wdvd_q;
                    rem_d = neg_r_q ? (~prem_q + NBIT'(1)) : prem_q;
                    dbz_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8b.sv
// tb_seq_divider_8b: directed vector table plus handshake/reset corner sequences.
module tb_seq_divider_8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic       signed_op = 1'b0;
`endif

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] prev_q = '0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] eq;
        logic [7:0] er;
        logic       ed;
        int         lat;
    } vec_t;

    seq_divider_8b #(.NBIT(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_op(input vec_t v);
        int n;
        bit got;
        @(negedge clk);
        dividend = v.a;
        divisor  = v.b;
        start    = 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
        signed_op = v.s;
`endif
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        check("busy_after_accept", int'(busy), 1);
        check("q_held_over_start", int'(quotient), int'(prev_q));
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (done) got = 1'b1;
        end
        check("done_latency", n, v.lat);
        check("quotient", int'(quotient), int'(v.eq));
        check("remainder", int'(remainder), int'(v.er));
        check("div_by_zero", int'(div_by_zero), int'(v.ed));
        check("busy_at_done", int'(busy), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", int'(done), 0);
        prev_q = v.eq;
    endtask

    initial begin
        vec_t vecs[10];
        vec_t v;
        int pulses, at_k;
        logic [7:0] cq, cr;

        vecs[0] = '{a: 8'd100, b: 8'd7,   s: 1'b0, eq: 8'd14,  er: 8'd2,  ed: 1'b0, lat: 9};
        vecs[1] = '{a: 8'd3,   b: 8'd200, s: 1'b0, eq: 8'd0,   er: 8'd3,  ed: 1'b0, lat: 9};
        vecs[2] = '{a: 8'd255, b: 8'd1,   s: 1'b0, eq: 8'd255, er: 8'd0,  ed: 1'b0, lat: 9};
        vecs[3] = '{a: 8'd5,   b: 8'd0,   s: 1'b0, eq: 8'hFF,  er: 8'd5,  ed: 1'b1, lat: 1};
        vecs[4] = '{a: 8'd0,   b: 8'd9,   s: 1'b0, eq: 8'd0,   er: 8'd0,  ed: 1'b0, lat: 9};
        vecs[5] = '{a: 8'd255, b: 8'd255, s: 1'b0, eq: 8'd1,   er: 8'd0,  ed: 1'b0, lat: 9};
        vecs[6] = '{a: 8'd254, b: 8'd17,  s: 1'b0, eq: 8'd14,  er: 8'd16, ed: 1'b0, lat: 9};
        vecs[7] = '{a: 8'd128, b: 8'd16,  s: 1'b0, eq: 8'd8,   er: 8'd0,  ed: 1'b0, lat: 9};
        vecs[8] = '{a: 8'd0,   b: 8'd0,   s: 1'b0, eq: 8'hFF,  er: 8'd0,  ed: 1'b1, lat: 1};
        vecs[9] = '{a: 8'd200, b: 8'd9,   s: 1'b0, eq: 8'd22,  er: 8'd2,  ed: 1'b0, lat: 9};

        // reset state
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_quotient", int'(quotient), 0);
        check("rst_remainder", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // start re-asserted during RUN (cycle 3) and DONE (cycle 9) is ignored
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        at_k   = 0;
        cq     = '0;
        cr     = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start    = (k == 3 || k == 9);
            dividend = start ? 8'd50 : 8'($urandom);
            divisor  = start ? 8'd5  : 8'($urandom);
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                at_k = k;
                cq   = quotient;
                cr   = remainder;
            end
        end
        start = 1'b0;
        check("ign_pulses", pulses, 1);
        check("ign_pulse_edge", at_k, 9);
        check("ign_quotient", int'(cq), 14);
        check("ign_remainder", int'(cr), 2);
        check("ign_not_queued", int'(busy), 0);
        prev_q = 8'd14;
        v = '{a: 8'd50, b: 8'd5, s: 1'b0, eq: 8'd10, er: 8'd0, ed: 1'b0, lat: 9};
        do_op(v);

        // reset mid-operation aborts with no done pulse
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_quotient", int'(quotient), 0);
        check("abort_remainder", int'(remainder), 0);
        check("abort_dbz", int'(div_by_zero), 0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        prev_q = '0;
        do_op(vecs[9]);

`ifdef SEQ_DIVIDER_SIGNED_EN
        v = '{a: 8'h9C, b: 8'd7,   s: 1'b1, eq: 8'hF2, er: 8'hFE, ed: 1'b0, lat: 9};
        do_op(v);
        v = '{a: 8'h80, b: 8'hFF,  s: 1'b1, eq: 8'h80, er: 8'h00, ed: 1'b0, lat: 9};
        do_op(v);
        v = '{a: 8'd100, b: 8'hF9, s: 1'b1, eq: 8'hF2, er: 8'h02, ed: 1'b0, lat: 9};
        do_op(v);
        v = '{a: 8'hFB, b: 8'd0,   s: 1'b1, eq: 8'hFF, er: 8'hFB, ed: 1'b1, lat: 1};
        do_op(v);
        v = '{a: 8'h9C, b: 8'd7,   s: 1'b0, eq: 8'd22, er: 8'd2,  ed: 1'b0, lat: 9};
        do_op(v);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
